// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I control path: FSM state codes, opcodes,
// ALU control codes, datapath select codes and the immediate-format decode.
package riscv_pkg;

    typedef logic [3:0] state_t;

    localparam state_t FETCH    = 4'd0;
    localparam state_t DECODE   = 4'd1;
    localparam state_t MEMADR   = 4'd2;
    localparam state_t MEMREAD  = 4'd3;
    localparam state_t MEMWB    = 4'd4;
    localparam state_t MEMWRITE = 4'd5;
    localparam state_t EXECUTER = 4'd6;
    localparam state_t EXECUTEI = 4'd7;
    localparam state_t ALUWB    = 4'd8;
    localparam state_t BEQ      = 4'd9;
    localparam state_t JAL      = 4'd10;
    localparam state_t ILLEGAL  = 4'd11;

    localparam state_t RESET_STATE = FETCH;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RD1    = 2'b10;

    localparam logic [1:0] SRC_B_RD2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT    = 2'b00;
    localparam logic [1:0] RES_DATA       = 2'b01;
    localparam logic [1:0] RES_ALU_RESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, so the extender can run in any state.
    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse alu_op plus funct fields onto the ALU control code.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // funct7b5 only selects sub for R-type; for addi it is immediate bit 10.
                    3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/
// writeback and drives every datapath enable and select; state is exported for debug.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic [2:0] alu_control,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       illegal,
    output state_t     state
);

    // Memory handshake: a request (fetch, load or store) is held steady in its state and
    // completes on the cycle mem_ready=1; the FSM leaves that state on the following edge.

    state_t     next_state;
    state_t     cur;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_update;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       mem_write_raw;

    always_ff @(posedge clk) begin
        if (reset) state <= RESET_STATE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:    if (mem_ready) next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECUTER;
                    OP_I:         next_state = EXECUTEI;
                    OP_BEQ:       next_state = BEQ;
                    OP_JAL:       next_state = JAL;
                    default:      next_state = ILLEGAL;
                endcase
            end
            MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) next_state = MEMWB;
            MEMWB:    next_state = FETCH;
            MEMWRITE: if (mem_ready) next_state = FETCH;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BEQ:      next_state = FETCH;
            JAL:      next_state = ALUWB;
            ILLEGAL:  next_state = ILLEGAL;
            default:  next_state = FETCH;
        endcase
    end

    // Outputs look like FETCH while reset is held, even before the register has reloaded.
    always_comb begin
        cur           = reset ? RESET_STATE : state;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RD2;
        result_src    = RES_ALU_OUT;
        adr_src       = 1'b0;
        alu_op        = ALU_OP_ADD;
        branch        = 1'b0;
        pc_update     = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        case (cur)
            FETCH: begin
                alu_src_b    = SRC_B_FOUR;
                result_src   = RES_ALU_RESULT;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
            end
            DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
            end
            MEMADR: begin
                alu_src_a = SRC_A_RD1;
                alu_src_b = SRC_B_IMM;
            end
            MEMREAD: adr_src = 1'b1;
            MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
            end
            MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = SRC_A_RD1;
                alu_op    = ALU_OP_FUNCT;
            end
            EXECUTEI: begin
                alu_src_a = SRC_A_RD1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_OP_FUNCT;
            end
            ALUWB: reg_write_raw = 1'b1;
            BEQ: begin
                alu_src_a = SRC_A_RD1;
                alu_op    = ALU_OP_SUB;
                branch    = 1'b1;
            end
            JAL: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm_src   = imm_src_for(op);
    assign ir_write  = ir_write_raw & ~reset;
    assign pc_write  = (pc_update | (branch & zero)) & ~reset;
    assign reg_write = reg_write_raw & ~reset;
    assign mem_write = mem_write_raw & ~reset;
    assign illegal   = (cur == ILLEGAL) & ~reset;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-level bench for multicycle_controller with a per-instruction
// phase-sequence model and per-cycle control expectations.
module tb_multicycle_controller;
    import riscv_pkg::*;

    typedef enum int {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_BAD} kind_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic [1:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic [2:0] alu_control;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       illegal;
    state_t     state;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    state_t exp_state_q[$];
    logic   exp_rdy_q[$];

    multicycle_controller dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .imm_src     (imm_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .adr_src     (adr_src),
        .alu_control (alu_control),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .illegal     (illegal),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s c%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Operation the ALU must perform for the instruction currently in the IR.
    function automatic logic [2:0] model_alu_exec(input logic [6:0] o, input logic [2:0] f3,
                                                  input logic f7);
        case (f3)
            3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] model_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    task automatic check_cycle(input state_t s, input logic in_rst);
        state_t     e;
        logic [1:0] sa, sb, rs;
        logic [2:0] ac;
        logic       iw, pw, rw, mw, ad, il;
        e  = in_rst ? FETCH : s;
        sa = 2'b00; sb = 2'b00; rs = 2'b00; ac = 3'b000;
        iw = 1'b0;  pw = 1'b0;  rw = 1'b0;  mw = 1'b0; ad = 1'b0; il = 1'b0;
        case (e)
            FETCH:    begin sb = 2'b10; rs = 2'b10; iw = mem_ready; pw = mem_ready; end
            DECODE:   begin sa = 2'b01; sb = 2'b01; end
            MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            MEMREAD:  ad = 1'b1;
            MEMWB:    begin rs = 2'b01; rw = 1'b1; end
            MEMWRITE: begin ad = 1'b1; mw = 1'b1; end
            EXECUTER: begin sa = 2'b10; ac = model_alu_exec(op, funct3, funct7b5); end
            EXECUTEI: begin sa = 2'b10; sb = 2'b01; ac = model_alu_exec(op, funct3, funct7b5); end
            ALUWB:    rw = 1'b1;
            BEQ:      begin sa = 2'b10; ac = 3'b001; pw = zero; end
            JAL:      begin sa = 2'b01; sb = 2'b10; pw = 1'b1; end
            ILLEGAL:  il = 1'b1;
            default:  ;
        endcase
        if (in_rst) begin
            iw = 1'b0; pw = 1'b0; rw = 1'b0; mw = 1'b0; il = 1'b0;
        end
        check_val("state",       32'(state),       32'(s));
        check_val("ir_write",    32'(ir_write),    32'(iw));
        check_val("pc_write",    32'(pc_write),    32'(pw));
        check_val("reg_write",   32'(reg_write),   32'(rw));
        check_val("mem_write",   32'(mem_write),   32'(mw));
        check_val("adr_src",     32'(adr_src),     32'(ad));
        check_val("alu_src_a",   32'(alu_src_a),   32'(sa));
        check_val("alu_src_b",   32'(alu_src_b),   32'(sb));
        check_val("result_src",  32'(result_src),  32'(rs));
        check_val("alu_control", 32'(alu_control), 32'(ac));
        check_val("imm_src",     32'(imm_src),     32'(model_imm(op)));
        check_val("illegal",     32'(illegal),     32'(il));
    endtask

    // One clock: drive inputs after the edge, check mid-cycle, then advance.
    task automatic step(input state_t s, input logic r, input int zmode, input logic in_rst);
        mem_ready = r;
        zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
        @(negedge clk);
        check_cycle(s, in_rst);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input state_t s, input logic r);
        exp_state_q.push_back(s);
        exp_rdy_q.push_back(r);
    endtask

    // Expected phase sequence of one instruction, including memory wait cycles.
    task automatic plan(input kind_t k, input int wf, input int wm);
        exp_state_q.delete();
        exp_rdy_q.delete();
        repeat (wf) push(FETCH, 1'b0);
        push(FETCH, 1'b1);
        push(DECODE, 1'($urandom_range(0, 1)));
        case (k)
            K_LW: begin
                push(MEMADR, 1'($urandom_range(0, 1)));
                repeat (wm) push(MEMREAD, 1'b0);
                push(MEMREAD, 1'b1);
                push(MEMWB, 1'($urandom_range(0, 1)));
            end
            K_SW: begin
                push(MEMADR, 1'($urandom_range(0, 1)));
                repeat (wm) push(MEMWRITE, 1'b0);
                push(MEMWRITE, 1'b1);
            end
            K_R: begin
                push(EXECUTER, 1'($urandom_range(0, 1)));
                push(ALUWB, 1'($urandom_range(0, 1)));
            end
            K_I: begin
                push(EXECUTEI, 1'($urandom_range(0, 1)));
                push(ALUWB, 1'($urandom_range(0, 1)));
            end
            K_BEQ: push(BEQ, 1'($urandom_range(0, 1)));
            K_JAL: begin
                push(JAL, 1'($urandom_range(0, 1)));
                push(ALUWB, 1'($urandom_range(0, 1)));
            end
            default: repeat (10) push(ILLEGAL, 1'($urandom_range(0, 1)));
        endcase
    endtask

    task automatic run_instr(input kind_t k, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input int wf, input int wm, input int zmode);
        state_t s;
        logic   r;
        op = o; funct3 = f3; funct7b5 = f7;
        plan(k, wf, wm);
        while (exp_state_q.size() > 0) begin
            s = exp_state_q.pop_front();
            r = exp_rdy_q.pop_front();
            step(s, r, zmode, 1'b0);
        end
    endtask

    function automatic logic [6:0] op_of(input kind_t k);
        case (k)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_BEQ:   return 7'b1100011;
            K_JAL:   return 7'b1101111;
            default: return 7'b1111111;
        endcase
    endfunction

    initial begin
        kind_t k;
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step(FETCH, 1'b1, -1, 1'b1);
        reset = 1'b0;

        run_instr(K_LW,  op_of(K_LW),  3'b010, 1'b0, 0, 0, -1);
        run_instr(K_SW,  op_of(K_SW),  3'b010, 1'b0, 0, 3, -1);
        run_instr(K_BEQ, op_of(K_BEQ), 3'b000, 1'b0, 0, 0, 1);
        run_instr(K_BEQ, op_of(K_BEQ), 3'b000, 1'b0, 1, 0, 0);
        run_instr(K_R,   op_of(K_R),   3'b000, 1'b1, 0, 0, -1);
        run_instr(K_I,   op_of(K_I),   3'b000, 1'b1, 0, 0, -1);
        run_instr(K_JAL, op_of(K_JAL), 3'b000, 1'b0, 2, 0, -1);

        // Reset mid-store: the write must drop immediately and never complete.
        op = op_of(K_SW); funct3 = 3'b010; funct7b5 = 1'b0;
        step(FETCH, 1'b1, -1, 1'b0);
        step(DECODE, 1'b0, -1, 1'b0);
        step(MEMADR, 1'b0, -1, 1'b0);
        step(MEMWRITE, 1'b0, -1, 1'b0);
        reset = 1'b1;
        step(MEMWRITE, 1'b0, -1, 1'b1);
        step(FETCH, 1'b1, -1, 1'b1);
        reset = 1'b0;
        run_instr(K_LW, op_of(K_LW), 3'b010, 1'b0, 0, 1, -1);

        for (int n = 0; n < 80; n++) begin
            k = kind_t'($urandom_range(0, 5));
            run_instr(k, op_of(k), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end

        run_instr(K_BAD, op_of(K_BAD), 3'b000, 1'b0, 0, 0, -1);
        reset = 1'b1;
        step(ILLEGAL, 1'b0, -1, 1'b1);
        reset = 1'b0;
        step(FETCH, 1'b0, -1, 1'b0);
        run_instr(K_I, op_of(K_I), 3'b111, 1'b0, 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit of the multicycle RV32I softcore; sits upstream of the immediate extender and datapath muxes.
- Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback, and drives all datapath enables and selects.
- Drives imm_src to the extender: I=00, S=01, B=10, J=11.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal. Memory accesses use a ready handshake.

Parameters:
- RESET_STATE, FETCH, state entered on reset (fixed; present for package consistency).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read/write this cycle
- imm_src  out  2  immediate format select to the extender
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1
- alu_src_b  out  2  00 RD2, 01 ImmExt, 10 constant 4
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- adr_src  out  1  0 PC, 1 Result
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- reg_write  out  1  register file write
- mem_write  out  1  data memory write
- illegal  out  1  unsupported opcode trapped (sticky)

Behaviour:
- State register is the only storage. All outputs are combinational from state, plus op/funct/zero/mem_ready where noted.
- Reset: state <= FETCH on any edge with reset=1, including mid-instruction; the in-flight instruction is abandoned.
- While reset=1: ir_write, pc_write, reg_write and mem_write are forced 0, illegal=0, and the other outputs take their FETCH values.
- imm_src decodes from op in every state: lw (0000011) and I-ALU (0010011) -> 00; sw (0100011) -> 01; beq (1100011) -> 10; jal (1101111) -> 11; otherwise 00.
- pc_write = pc_update | (branch & zero).
- Output defaults (anything not listed for a state): enables 0, selects 00, alu_op 00.
- FETCH: adr_src=0, src_a=00, src_b=10, result_src=10, alu_op=00. ir_write and pc_update equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: src_a=01, src_b=01, alu_op=00 (branch target into ALUOut). Next state by op:
  - lw/sw -> MEMADR
  - R (0110011) -> EXECUTER
  - I-ALU -> EXECUTEI
  - beq -> BEQ
  - jal -> JAL
  - any other op -> ILLEGAL
- MEMADR: src_a=10, src_b=01, alu_op=00. Go to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: result_src=00, adr_src=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1 held continuously until mem_ready=1, then FETCH. The write completes exactly once.
- EXECUTER: src_a=10, src_b=00, alu_op=10, then ALUWB.
- EXECUTEI: src_a=10, src_b=01, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, branch=1, then FETCH.
- JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_update=1, then ALUWB (writes PC+4 to rd).
- ILLEGAL: no enables asserted, illegal=1. Stays in ILLEGAL until reset.
- ALU decode:
  - alu_op 00 -> 000; alu_op 01 -> 001.
  - alu_op 10, by funct3:
    - 000 -> 001 if (funct7b5 & op[5]) else 000
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - others -> 000
- Latency: lw 5 cycles; sw, R, I and jal 4 cycles; beq 3 cycles; each with zero-wait memory. Every mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Decomposition:
- Shared package riscv_pkg holds:
  - state enum
  - opcode constants
  - ALU control codes
  - alu_src_a/alu_src_b/result_src select codes
  - imm_src codes (also used by the extender)
- Sub-module alu_decoder (alu_op, funct3, funct7b5, op5 -> alu_control) is purely combinational and instantiated once.

Test Plan:
- Reset held 2 cycles mid-MEMWRITE -> mem_write=0 during reset; first edge after release shows state FETCH, ir_write=pc_write=mem_ready.
- lw (op=0000011), mem_ready=1 -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; imm_src=00; reg_write=1 only in MEMWB with result_src=01.
- sw with mem_ready low for 3 cycles in MEMWRITE -> mem_write=1 for 4 consecutive cycles; imm_src=01; FETCH on the cycle after mem_ready=1.
- beq, zero=1 vs zero=0 -> pc_write=1 in BEQ only when zero=1; imm_src=10; alu_control=001.
- R-type sub (funct3=000, funct7b5=1) -> alu_control=001. addi with funct7b5=1 -> alu_control=000. jal -> imm_src=11, pc_write=1 in JAL, reg_write=1 in the following ALUWB.
- op=1111111 -> ILLEGAL after DECODE; illegal=1 and no writes for 10 cycles; reset clears it.
